// File: rtl/divider_if.sv
// Start/result handshake bundle for the iterative divider.
// div_zero exists only when DIVIDER_ZERO_DETECT_EN is defined.
interface divider_if #(
  parameter int WIDTH = 32
);
  logic             div_begin;
  logic             div_signed;
  logic [WIDTH-1:0] div_op1;
  logic [WIDTH-1:0] div_op2;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_busy;
  logic             div_end;
`ifdef DIVIDER_ZERO_DETECT_EN
  logic             div_zero;
`endif

  modport master (
    output div_begin, div_signed, div_op1, div_op2,
    input  quotient, remainder, div_busy, div_end
`ifdef DIVIDER_ZERO_DETECT_EN
    , input div_zero
`endif
  );

  modport slave (
    input  div_begin, div_signed, div_op1, div_op2,
    output quotient, remainder, div_busy, div_end
`ifdef DIVIDER_ZERO_DETECT_EN
    , output div_zero
`endif
  );
endinterface

// File: rtl/divider.sv
// Iterative restoring divider, one quotient bit per clock, signed or unsigned.
// Optional feature macro: DIVIDER_ZERO_DETECT_EN (zero-divisor short-cut and div_zero flag).
module divider #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  divider_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             zero_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] qd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             q_neg_q;
  logic             r_neg_q;

  logic             accept;
  logic             op2_zero;
  logic [WIDTH:0]   r_sh;
  logic             ge;
  logic [WIDTH-1:0] r_nx;
  logic [WIDTH-1:0] q_nx;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
    logic signed [WIDTH-1:0] s;
    s = signed'(v);
    return (sgn && s[WIDTH-1]) ? WIDTH'(-s) : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    logic signed [WIDTH-1:0] s;
    s = signed'(v);
    return neg ? WIDTH'(-s) : v;
  endfunction

  assign accept = bus.div_begin && ((state_q == IDLE) || (state_q == DONE));

`ifdef DIVIDER_ZERO_DETECT_EN
  assign op2_zero = (bus.div_op2 == '0);
`else
  assign op2_zero = 1'b0;
`endif

  // The shifted partial remainder can reach 2*divisor-1, hence one extra bit.
  always_comb begin
    r_sh = {r_q, qd_q[WIDTH-1]};
    ge   = (r_sh >= {1'b0, dvs_q});
    r_nx = ge ? WIDTH'(r_sh - {1'b0, dvs_q}) : r_sh[WIDTH-1:0];
    q_nx = {qd_q[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.div_begin) state_d = BUSY;
      BUSY:    if (cnt_q == '0)   state_d = DONE;
      DONE:    if (bus.div_begin) state_d = BUSY;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.div_busy  = (state_q == BUSY) && !zero_q;
    bus.div_end   = (state_q == DONE);
    bus.quotient  = quot_q;
    bus.remainder = rem_q;
`ifdef DIVIDER_ZERO_DETECT_EN
    bus.div_zero  = zero_q;
`endif
  end

  // Control and result registers; a zero divisor enters BUSY with count 0 and finishes next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      zero_q <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
    end else if (accept) begin
      cnt_q  <= op2_zero ? '0 : CNT_W'(WIDTH);
      zero_q <= op2_zero;
    end else if (state_q == BUSY) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end else begin
        quot_q <= zero_q ? '1   : cond_neg(qd_q, q_neg_q);
        rem_q  <= zero_q ? qd_q : cond_neg(r_q, r_neg_q);
      end
    end
  end

  // Working datapath; qd_q holds the raw dividend when the zero short-cut is taken.
  always_ff @(posedge clk) begin
    if (accept) begin
      r_q     <= '0;
      qd_q    <= op2_zero ? bus.div_op1 : abs_val(bus.div_op1, bus.div_signed);
      dvs_q   <= abs_val(bus.div_op2, bus.div_signed);
      q_neg_q <= bus.div_signed && (bus.div_op1[WIDTH-1] ^ bus.div_op2[WIDTH-1]);
      r_neg_q <= bus.div_signed && bus.div_op1[WIDTH-1];
    end else if ((state_q == BUSY) && (cnt_q != '0)) begin
      r_q  <= r_nx;
      qd_q <= q_nx;
    end
  end
endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for divider (WIDTH=32), both macro configurations.
module tb_divider;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  divider_if #(.WIDTH(W)) bus ();
  divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  // Drives one request and counts edges after the accept edge until div_end; -1 on timeout.
  task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
    @(negedge clk);
    bus.div_begin = 1'b1; bus.div_signed = sgn; bus.div_op1 = a; bus.div_op2 = b;
    @(posedge clk); #1;
    bus.div_begin = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.div_end === 1'b1) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.quotient !== 32'd0) begin failures++; $display("FAIL reset_quot got=%h exp=0", bus.quotient); end
    checks++; if (bus.remainder !== 32'd0) begin failures++; $display("FAIL reset_rem got=%h exp=0", bus.remainder); end
    checks++; if (bus.div_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.div_busy); end
    checks++; if (bus.div_end !== 1'b0) begin failures++; $display("FAIL reset_end got=%b exp=0", bus.div_end); end
`ifdef DIVIDER_ZERO_DETECT_EN
    checks++; if (bus.div_zero !== 1'b0) begin failures++; $display("FAIL reset_zero got=%b exp=0", bus.div_zero); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat;
    run_op(1'b0, 32'd100, 32'd7, lat);
    checks++; if (lat != 33) begin failures++; $display("FAIL unsigned_latency got=%0d exp=33", lat); end
    checks++; if (bus.quotient !== 32'd14) begin failures++; $display("FAIL unsigned_quot got=%h exp=%h", bus.quotient, 32'd14); end
    checks++; if (bus.remainder !== 32'd2) begin failures++; $display("FAIL unsigned_rem got=%h exp=%h", bus.remainder, 32'd2); end
    checks++; if (bus.div_busy !== 1'b0) begin failures++; $display("FAIL unsigned_busy_done got=%b exp=0", bus.div_busy); end
  endtask

  task automatic test_signed();
    int lat;
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat);
    checks++; if (bus.quotient !== 32'hFFFF_FFFD) begin failures++; $display("FAIL signed_m7_d2_quot got=%h exp=FFFFFFFD", bus.quotient); end
    checks++; if (bus.remainder !== 32'hFFFF_FFFF) begin failures++; $display("FAIL signed_m7_d2_rem got=%h exp=FFFFFFFF", bus.remainder); end
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat);
    checks++; if (bus.quotient !== 32'hFFFF_FFFD) begin failures++; $display("FAIL signed_7_dm2_quot got=%h exp=FFFFFFFD", bus.quotient); end
    checks++; if (bus.remainder !== 32'd1) begin failures++; $display("FAIL signed_7_dm2_rem got=%h exp=1", bus.remainder); end
  endtask

  task automatic test_boundary();
    int lat;
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    checks++; if (bus.quotient !== 32'h8000_0000) begin failures++; $display("FAIL min_div_m1_quot got=%h exp=80000000", bus.quotient); end
    checks++; if (bus.remainder !== 32'd0) begin failures++; $display("FAIL min_div_m1_rem got=%h exp=0", bus.remainder); end
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, lat);
    checks++; if (bus.quotient !== 32'hFFFF_FFFF) begin failures++; $display("FAIL max_div_1_quot got=%h exp=FFFFFFFF", bus.quotient); end
    checks++; if (bus.remainder !== 32'd0) begin failures++; $display("FAIL max_div_1_rem got=%h exp=0", bus.remainder); end
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(1'b0, 32'd5, 32'd0, lat);
`ifdef DIVIDER_ZERO_DETECT_EN
    checks++; if (lat != 1) begin failures++; $display("FAIL divzero_latency got=%0d exp=1", lat); end
    checks++; if (bus.div_zero !== 1'b1) begin failures++; $display("FAIL divzero_flag got=%b exp=1", bus.div_zero); end
`else
    checks++; if (lat != 33) begin failures++; $display("FAIL divzero_latency got=%0d exp=33", lat); end
`endif
    checks++; if (bus.quotient !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divzero_quot got=%h exp=FFFFFFFF", bus.quotient); end
    checks++; if (bus.remainder !== 32'd5) begin failures++; $display("FAIL divzero_rem got=%h exp=5", bus.remainder); end
`ifdef DIVIDER_ZERO_DETECT_EN
    run_op(1'b0, 32'd9, 32'd4, lat);
    checks++; if (bus.div_zero !== 1'b0) begin failures++; $display("FAIL divzero_clear got=%b exp=0", bus.div_zero); end
`endif
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    bus.div_begin = 1'b1; bus.div_signed = 1'b0; bus.div_op1 = 32'd100; bus.div_op2 = 32'd7;
    @(posedge clk); #1;
    bus.div_begin = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      if (i == 10) begin
        bus.div_begin = 1'b1; bus.div_op1 = 32'd50; bus.div_op2 = 32'd5; bus.div_signed = 1'b1;
      end
      @(posedge clk); #1;
      bus.div_begin = 1'b0;
      if (bus.div_end === 1'b1) begin lat = i; break; end
    end
    checks++; if (lat != 33) begin failures++; $display("FAIL ignore_latency got=%0d exp=33", lat); end
    checks++; if (bus.quotient !== 32'd14) begin failures++; $display("FAIL ignore_quot got=%h exp=%h", bus.quotient, 32'd14); end
    checks++; if (bus.remainder !== 32'd2) begin failures++; $display("FAIL ignore_rem got=%h exp=%h", bus.remainder, 32'd2); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (bus.div_end !== 1'b1 || bus.quotient !== 32'd14) begin failures++; $display("FAIL done_hold got end=%b quot=%h exp end=1 quot=%h", bus.div_end, bus.quotient, 32'd14); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    bus.div_begin = 1'b1; bus.div_signed = 1'b0; bus.div_op1 = 32'd9; bus.div_op2 = 32'd2;
    @(posedge clk); #1;
    bus.div_begin = 1'b0;
    checks++; if (bus.div_end !== 1'b0) begin failures++; $display("FAIL b2b_end_drop got=%b exp=0", bus.div_end); end
    checks++; if (bus.div_busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", bus.div_busy); end
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.div_end === 1'b1) begin lat = i; break; end
    end
    checks++; if (lat != 33) begin failures++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
    checks++; if (bus.quotient !== 32'd4 || bus.remainder !== 32'd1) begin failures++; $display("FAIL b2b_result got q=%h r=%h exp q=4 r=1", bus.quotient, bus.remainder); end
  endtask

  task automatic test_reset_busy();
    int lat;
    @(negedge clk);
    bus.div_begin = 1'b1; bus.div_signed = 1'b0; bus.div_op1 = 32'd100; bus.div_op2 = 32'd7;
    @(posedge clk); #1;
    bus.div_begin = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.div_begin = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.div_begin = 1'b0;
    checks++; if (bus.div_busy !== 1'b0 || bus.div_end !== 1'b0) begin failures++; $display("FAIL rstbusy_ctrl got busy=%b end=%b exp 0 0", bus.div_busy, bus.div_end); end
    checks++; if (bus.quotient !== 32'd0 || bus.remainder !== 32'd0) begin failures++; $display("FAIL rstbusy_data got q=%h r=%h exp 0 0", bus.quotient, bus.remainder); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.div_busy !== 1'b0) begin failures++; $display("FAIL rstbusy_idle got busy=%b exp=0", bus.div_busy); end
    run_op(1'b0, 32'd9, 32'd3, lat);
    checks++; if (lat != 33) begin failures++; $display("FAIL after_rst_latency got=%0d exp=33", lat); end
    checks++; if (bus.quotient !== 32'd3 || bus.remainder !== 32'd0) begin failures++; $display("FAIL after_rst_result got q=%h r=%h exp q=3 r=0", bus.quotient, bus.remainder); end
  endtask

  initial begin
    bus.div_begin = 1'b0; bus.div_signed = 1'b0; bus.div_op1 = '0; bus.div_op2 = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_boundary();
    test_div_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
